// File: rtl/nios2_sysid_checker.sv
// nios2_sysid_checker: reads sysid ID and timestamp over Avalon-MM and reports pass, fail or timeout
module nios2_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS = 32'h5A61_90D4,
  parameter int READ_LATENCY = 1,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRIES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        sysid_address,
  output logic        sysid_read,
  input  logic        sysid_waitrequest,
  input  logic [31:0] sysid_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [2:0]  retry_count
);
  typedef enum logic [2:0] {IDLE, CMD_ID, LAT_ID, CMD_TS, LAT_TS, CHECK} state_t;
  localparam logic NO_LAT = READ_LATENCY == 0;
  localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRIES);
  state_t state, state_n;
  logic [15:0] wait_cnt;
  logic [1:0] lat_cnt;
  logic cmd, lat, check, accept, expired, lat_end, cap_id, cap_ts, match, can_retry, go, finish, retry;
  assign cmd = state == CMD_ID || state == CMD_TS;
  assign lat = state == LAT_ID || state == LAT_TS;
  assign check = state == CHECK;
  assign accept = cmd && !sysid_waitrequest;
  assign expired = cmd && sysid_waitrequest && wait_cnt == WAIT_LAST;
  assign lat_end = lat && lat_cnt == LAT_LAST;
  assign cap_id = NO_LAT ? state == CMD_ID && accept : state == LAT_ID && lat_end;
  assign cap_ts = NO_LAT ? state == CMD_TS && accept : state == LAT_TS && lat_end;
  assign match = id_value == EXPECTED_ID && ts_value == EXPECTED_TS;
  assign can_retry = retry_count < RETRY_MAX;
  assign go = state == IDLE && start && !done;
  assign finish = check && (match || !can_retry);
  assign retry = check && !match && can_retry;
  assign sysid_read = cmd;
  assign sysid_address = state == CMD_TS;
  assign busy = state != IDLE || done;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = go ? CMD_ID : IDLE;
      CMD_ID:  state_n = expired ? IDLE : accept ? (NO_LAT ? CMD_TS : LAT_ID) : CMD_ID;
      LAT_ID:  state_n = lat_end ? CMD_TS : LAT_ID;
      CMD_TS:  state_n = expired ? IDLE : accept ? (NO_LAT ? CHECK : LAT_TS) : CMD_TS;
      LAT_TS:  state_n = lat_end ? CHECK : LAT_TS;
      CHECK:   state_n = finish ? IDLE : CMD_ID;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      wait_cnt <= '0;
      lat_cnt <= '0;
      done <= 1'b0;
      pass <= 1'b0;
      fail <= 1'b0;
      timeout_err <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
      retry_count <= '0;
    end else begin
      state <= state_n;
      wait_cnt <= cmd && sysid_waitrequest ? wait_cnt + 16'd1 : '0;
      lat_cnt <= lat && !lat_end ? lat_cnt + 2'd1 : '0;
      done <= expired || finish;
      pass <= !go && (pass || (check && match));
      fail <= !go && (fail || (check && !match && !can_retry));
      timeout_err <= !go && (timeout_err || expired);
      retry_count <= go ? '0 : retry ? retry_count + 3'd1 : retry_count;
      id_value <= cap_id ? sysid_readdata : id_value;
      ts_value <= cap_ts ? sysid_readdata : ts_value;
    end
  end
endmodule
